ps2_rx_deframer: RTL
====================

Name: ps2_rx_deframer

Overview:
- Receive-only PS/2 device-to-host deframer. Turns the raw PS2_CLK/PS2_DAT lines into one validated scancode byte per frame, with a single-cycle strobe.
- Sits directly upstream of the scancode parser / LUT stage. Its received_data and received_data_en feed that stage's ps2_data and available inputs unchanged.
- Checks start, parity and stop bits, rejects clock glitches, and recovers from truncated frames by timeout.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronised ps2_clk samples needed before the filtered clock changes. Range 2..255.
- TIMEOUT_CYCLES, 10000: CLOCK_50 cycles allowed between filtered falling edges inside a frame before the frame is abandoned (200 us at 50 MHz).
- CW, 14: width of the timeout counter. Must satisfy 2^CW > TIMEOUT_CYCLES.

Ports:
- CLOCK_50  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS2_CLK pin; this block never drives it.
- ps2_dat  in  1  raw PS2_DAT pin; this block never drives it.
- received_data  out  8  last good byte; holds its value between frames.
- received_data_en  out  1  one-cycle strobe: received_data is valid and new.
- parity_err  out  1  one-cycle pulse: frame dropped because of an odd-parity failure.
- frame_err  out  1  one-cycle pulse: frame dropped because the stop bit was 0 or a timeout fired mid-frame.
- busy  out  1  high from the start bit until the frame completes or aborts.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, synchronisers and filtered clock 1, counters 0.
- Synchronisation: ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
- Glitch filter:
  - A saturating counter counts cycles where the synchronised clock differs from the filtered clock.
  - The counter clears on any cycle where the two agree.
  - When the count reaches FILTER_LEN-1 and they still differ, the filtered clock toggles.
- fall: a one-cycle pulse on a filtered 1->0 transition. All sampling happens on fall, using the synchronised ps2_dat.
- FSM states, all transitions taken on fall:
  - IDLE: if dat=0, go to DATA with bit index 0. If dat=1 (bad start bit), stay in IDLE silently.
  - DATA: shift dat into shreg LSB-first. After index 7, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP:
    - If dat=1 and XOR(shreg, parity)=1 (odd parity correct): received_data<=shreg, received_data_en<=1.
    - If dat=1 and parity is wrong: parity_err<=1.
    - If dat=0: frame_err<=1, whatever the parity.
    - In every case return to IDLE.
- Latency: the output pulse is asserted on the cycle after the stop-bit fall and lasts exactly 1 cycle. received_data is updated on that same cycle.
- Timeout:
  - Counter clears on every fall and in IDLE, and increments in any other state.
  - When it reaches TIMEOUT_CYCLES: frame_err pulses, FSM goes to IDLE, shreg is discarded.
  - A fall on the same cycle takes priority: the counter clears and the FSM advances, with no error.
- busy = (state != IDLE).
- Errors never modify received_data. The pulse outputs are mutually exclusive.
- Asynchronous reset mid-frame: outputs return to 0 immediately. The next frame is accepted only when a fresh start bit arrives.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0, which the downstream parser also uses;
  - default TIMEOUT_CYCLES.
- One natural sub-module, ps2_sync_filter: the 2-flop synchroniser plus glitch filter plus fall-edge detector, parameterised by FILTER_LEN. It is instantiated once for the clock line. The data line uses only the synchroniser section.

Test Plan:
- Frame for byte 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1), 40 us per half bit period -> exactly one received_data_en pulse with received_data=0x1C; no error pulses; busy low afterwards.
- Back-to-back frames 0xF0 (parity 1) then 0x1C -> two strobes in order, F0 then 1C. received_data holds 0x1C until the next frame.
- Frame 0x1C with parity bit 1 -> parity_err pulses once; no strobe; received_data keeps its previous value.
- Frame 0x1C with stop bit 0 -> frame_err pulses; no strobe. A following good 0x29 frame is received correctly.
- Clock stops after 5 data bits -> frame_err pulses exactly TIMEOUT_CYCLES cycles after the last fall; busy drops. A following good frame 0x5A is accepted.
- 3-cycle low glitch on ps2_clk while idle (FILTER_LEN=8) -> no state change, no pulses.
- Assert reset_n low at bit 4 of a frame, release it, then send 0x76 -> outputs are 0 during reset; only 0x76 is strobed, with no error pulses.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: deframer FSM states, protocol constants
// used by both the deframer and the downstream scancode parser.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    // Scancode prefixes the downstream parser keys on.
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    // 200 us at 50 MHz: comfortably longer than the slowest legal PS/2 bit.
    localparam int PS2_TIMEOUT_DEFAULT = 10000;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser, glitch filter and falling-edge detector for the
// PS/2 clock line. The filtered clock only changes after the synchronised
// input has disagreed with it for FILTER_LEN consecutive cycles.
module ps2_sync_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic fall
);

    localparam logic [7:0] CNT_LAST = 8'(FILTER_LEN - 1);

    logic sync_1;
    logic sync_2;
    logic filt;
    logic [7:0] cnt;

    // Bring the asynchronous pin into the clk domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Count disagreeing cycles; toggle the filtered level once the count
    // is full and the input still disagrees. fall marks a 1->0 toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b1;
            cnt  <= 8'd0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_2 == filt) begin
                cnt <= 8'd0;
            end else if (cnt == CNT_LAST) begin
                filt <= sync_2;
                cnt  <= 8'd0;
                fall <= filt;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_deframer.sv
// PS/2 device-to-host deframer: samples data on filtered clock falls,
// checks start/parity/stop, and emits one strobe per good byte. A timeout
// abandons frames whose clock stops part-way through.
module ps2_rx_deframer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT,
    parameter int CW             = 14
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    // The timeout fires on the edge where the counter would reach TIMEOUT_CYCLES.
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic fall;
    logic dat_1;
    logic dat_2;

    ps2_state_t state, state_d;
    logic [2:0]    idx, idx_d;
    logic [7:0]    shreg, shreg_d;
    logic          par, par_d;
    logic [CW-1:0] tcnt, tcnt_d;
    logic [7:0]    rd_d;
    logic          en_d;
    logic          perr_d;
    logic          ferr_d;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .raw   (ps2_clk),
        .fall  (fall)
    );

    // Data line only needs synchronising; it is sampled on filtered falls.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            dat_1 <= 1'b1;
            dat_2 <= 1'b1;
        end else begin
            dat_1 <= ps2_dat;
            dat_2 <= dat_1;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= 3'd0;
            shreg            <= 8'd0;
            par              <= 1'b0;
            tcnt             <= '0;
            received_data    <= 8'd0;
            received_data_en <= 1'b0;
            parity_err       <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            state            <= state_d;
            idx              <= idx_d;
            shreg            <= shreg_d;
            par              <= par_d;
            tcnt             <= tcnt_d;
            received_data    <= rd_d;
            received_data_en <= en_d;
            parity_err       <= perr_d;
            frame_err        <= ferr_d;
        end
    end

    // Next-state: advance on fall; otherwise watch the inter-fall timeout.
    always_comb begin
        state_d = state;
        idx_d   = idx;
        shreg_d = shreg;
        par_d   = par;
        tcnt_d  = tcnt;
        rd_d    = received_data;
        en_d    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;

        if (state == IDLE || fall) begin
            tcnt_d = '0;
        end else begin
            tcnt_d = tcnt + CW'(1);
        end

        if (fall) begin
            unique case (state)
                IDLE: begin
                    // A high start bit is ignored; wait for a real start.
                    if (!dat_2) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    // LSB arrives first, so shift in from the top.
                    shreg_d = {dat_2, shreg[7:1]};
                    idx_d   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    par_d   = dat_2;
                    state_d = STOP;
                end
                STOP: begin
                    if (!dat_2) begin
                        ferr_d = 1'b1;
                    end else if (odd_parity_ok(shreg, par)) begin
                        rd_d = shreg;
                        en_d = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state != IDLE && tcnt == TO_LAST) begin
            ferr_d  = 1'b1;
            state_d = IDLE;
            tcnt_d  = '0;
            shreg_d = 8'd0;
        end
    end

    assign busy = (state != IDLE);

endmodule
